// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 access codes,
// clear-FSM states and access-size decode.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int WORDS = 128;

    typedef enum logic {ST_CLEAR, ST_READY} dmem_state_t;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} dmem_size_t;

    // Unlisted funct3 codes (011, 110, 111) fall through to a word access.
    function automatic dmem_size_t f3_size(input logic [2:0] f3);
        dmem_size_t sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_BYTE;
            F3_H, F3_HU: sz = SZ_HALF;
            default:     sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: load extraction/extension, store byte-enables,
// store data replication and the alignment check.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_data,
    output logic [31:0] ld_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    output logic        misaligned
);

    dmem_size_t  size;
    logic        sext;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        size       = f3_size(funct3);
        sext       = ~funct3[2];
        byte_v     = rd_word[{lane, 3'b000} +: 8];
        half_v     = rd_word[{lane[1], 4'b0000} +: 16];
        ld_data    = rd_word;
        st_be      = 4'b1111;
        st_data    = wr_data;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                ld_data = {{24{sext & byte_v[7]}}, byte_v};
                st_be   = 4'b0001 << lane;
                st_data = {4{wr_data[7:0]}};
            end
            SZ_HALF: begin
                // Halfword uses its lane pair regardless of lane[0]; the
                // misaligned flag is what suppresses the access.
                ld_data    = {{16{sext & half_v[15]}}, half_v};
                st_be      = lane[1] ? 4'b1100 : 4'b0011;
                st_data    = {2{wr_data[15:0]}};
                misaligned = lane[0];
            end
            default: begin
                misaligned = |lane;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// 512-byte data memory responder with byte/half/word loads and stores.
// Optional power-up zeroing of the array is enabled by defining DMEM_CLEAR_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              misaligned,
    output logic              busy,
    output dmem_state_t       dbg_state
);

    localparam int IDX_W = ADDR_W - 2;

    // Handshake: wr/rd are single-cycle qualifiers taken on any edge where
    // busy is low (no other backpressure); every accepted load yields exactly
    // one rd_valid pulse on the following cycle, misaligned or not.

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] ld_data;
    logic [3:0]        st_be;
    logic [DATA_W-1:0] st_data;
    logic              al_mis;
    logic              accept_rd;
    logic              accept_wr;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;

    assign idx       = addr[ADDR_W-1:2];
    assign lane      = addr[1:0];
    assign rd_word   = mem[idx];
    assign accept_rd = rd & ~busy;
    assign accept_wr = wr & ~busy;

    dmem_lane_align u_align (
        .funct3     (funct3),
        .lane       (lane),
        .rd_word    (rd_word),
        .wr_data    (wr_data),
        .ld_data    (ld_data),
        .st_be      (st_be),
        .st_data    (st_data),
        .misaligned (al_mis)
    );

`ifdef DMEM_CLEAR_EN
    dmem_state_t      state_q;
    dmem_state_t      state_d;
    logic [IDX_W-1:0] clr_cnt_q;
    logic [IDX_W-1:0] clr_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == IDX_W'(DEPTH - 1))
                    state_d = ST_READY;
            end
            ST_READY: begin
                state_d = ST_READY;
            end
        endcase
    end

    assign busy      = (state_q == ST_CLEAR);
    assign dbg_state = state_q;
`else
    assign busy      = 1'b0;
    assign dbg_state = ST_READY;
`endif

    // Single write port shared between the clear sweep and core stores.
    always_comb begin
        mem_we    = accept_wr & ~al_mis;
        mem_idx   = idx;
        mem_be    = st_be;
        mem_wdata = st_data;
`ifdef DMEM_CLEAR_EN
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_idx   = clr_cnt_q;
            mem_be    = 4'b1111;
            mem_wdata = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i])
                    mem[mem_idx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
        end
    end

    // rd_word is sampled before the store lands, which gives read-first
    // behaviour when wr and rd hit the same word together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            rd_valid   <= accept_rd;
            misaligned <= (accept_rd | accept_wr) & al_mis;
            if (accept_rd)
                rd_data <= al_mis ? '0 : ld_data;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; also covers the
// DMEM_CLEAR_EN sweep when that macro is defined.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk;
    logic        reset;
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [2:0]  funct3;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        misaligned;
    logic        busy;
    dmem_state_t dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    dmem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .rd         (rd),
        .addr       (addr),
        .funct3     (funct3),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .misaligned (misaligned),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    // driver tasks: each applies one request for one edge, then samples 1ns later
    task automatic drive(input logic w, input logic r, input logic [8:0] a,
                         input logic [2:0] f3, input logic [31:0] d);
        wr = w; rd = r; addr = a; funct3 = f3; wr_data = d;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [8:0] a, input logic [2:0] f3,
                            input logic [31:0] d, input logic exp_mis);
        drive(1'b1, 1'b0, a, f3, d);
        check({tag, " valid"}, 32'(rd_valid), 32'd0);
        check({tag, " mis"}, 32'(misaligned), 32'(exp_mis));
    endtask

    task automatic do_load(input string tag, input logic [8:0] a, input logic [2:0] f3,
                           input logic [31:0] exp, input logic exp_mis);
        exp_q.push_back(exp);
        drive(1'b0, 1'b1, a, f3, 32'h0);
        check({tag, " valid"}, 32'(rd_valid), 32'd1);
        check({tag, " data"}, rd_data, exp_q.pop_front());
        check({tag, " mis"}, 32'(misaligned), 32'(exp_mis));
    endtask

    task automatic do_both(input string tag, input logic [8:0] a, input logic [2:0] f3,
                           input logic [31:0] d, input logic [31:0] exp, input logic exp_mis);
        exp_q.push_back(exp);
        drive(1'b1, 1'b1, a, f3, d);
        check({tag, " valid"}, 32'(rd_valid), 32'd1);
        check({tag, " data"}, rd_data, exp_q.pop_front());
        check({tag, " mis"}, 32'(misaligned), 32'(exp_mis));
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (busy && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; funct3 = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst rd_data", rd_data, 32'h0);
        check("rst rd_valid", 32'(rd_valid), 32'd0);
        check("rst mis", 32'(misaligned), 32'd0);
`ifdef DMEM_CLEAR_EN
        check("rst busy", 32'(busy), 32'd1);
        cyc = 0;
        while (busy && cyc < 400) begin
            if (cyc == 10) begin
                rd = 1'b1; addr = 9'h010; funct3 = F3_W;
            end
            @(posedge clk);
            #1;
            rd = 1'b0;
            cyc++;
            if (cyc == 11)
                check("busy load ignored", 32'(rd_valid), 32'd0);
        end
        check("clear cycles", 32'(cyc), 32'd128);
        // reset pulsed partway through a fresh sweep restarts it
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("busy at reset50", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        wait_ready(cyc);
        check("clear cycles after reset50", 32'(cyc), 32'd128);
        do_load("LW 1FC cleared", 9'h1FC, F3_W, 32'h0, 1'b0);
        do_load("LW 010 cleared", 9'h010, F3_W, 32'h0, 1'b0);
`else
        check("rst busy", 32'(busy), 32'd0);
`endif

        // word / byte / half basics
        do_store("SW 010", 9'h010, F3_W, 32'hDEADBEEF, 1'b0);
        do_load("LW 010", 9'h010, F3_W, 32'hDEADBEEF, 1'b0);
        do_store("SB 013", 9'h013, F3_B, 32'h12345680, 1'b0);
        do_load("LB 013", 9'h013, F3_B, 32'hFFFFFF80, 1'b0);
        do_load("LBU 013", 9'h013, F3_BU, 32'h00000080, 1'b0);
        do_load("LW 010 after SB", 9'h010, F3_W, 32'h80ADBEEF, 1'b0);
        do_load("LB 010", 9'h010, F3_B, 32'hFFFFFFEF, 1'b0);
        do_load("LBU 011", 9'h011, F3_BU, 32'h000000BE, 1'b0);
        do_load("LH 012", 9'h012, F3_H, 32'hFFFF80AD, 1'b0);
        do_load("LHU 012", 9'h012, F3_HU, 32'h000080AD, 1'b0);
        do_store("SW 020", 9'h020, F3_W, 32'h55667788, 1'b0);
        do_store("SH 022", 9'h022, F3_H, 32'hABCD8001, 1'b0);
        do_load("LH 022", 9'h022, F3_H, 32'hFFFF8001, 1'b0);
        do_load("LHU 022", 9'h022, F3_HU, 32'h00008001, 1'b0);
        do_load("LW 020", 9'h020, F3_W, 32'h80017788, 1'b0);
        do_load("LH 020", 9'h020, F3_H, 32'h00007788, 1'b0);
        do_load("LB 021", 9'h021, F3_B, 32'h00000077, 1'b0);

        // funct3 aliases of W
        do_load("L011 010", 9'h010, 3'b011, 32'h80ADBEEF, 1'b0);
        do_load("L110 010", 9'h010, 3'b110, 32'h80ADBEEF, 1'b0);
        do_load("L111 010", 9'h010, 3'b111, 32'h80ADBEEF, 1'b0);

        // misaligned accesses
        do_load("LW 011 mis", 9'h011, F3_W, 32'h0, 1'b1);
        do_load("LH 023 mis", 9'h023, F3_H, 32'h0, 1'b1);
        do_load("LHU 013 mis", 9'h013, F3_HU, 32'h0, 1'b1);
        do_store("SH 021 mis", 9'h021, F3_H, 32'h0000FFFF, 1'b1);
        do_load("LW 020 unchanged", 9'h020, F3_W, 32'h80017788, 1'b0);

        // read-first with simultaneous wr and rd
        do_store("SW 030", 9'h030, F3_W, 32'h11111111, 1'b0);
        do_both("WR+RD 030", 9'h030, F3_W, 32'h22222222, 32'h11111111, 1'b0);
        do_load("LW 030 new", 9'h030, F3_W, 32'h22222222, 1'b0);
        do_both("WR+RD 031 mis", 9'h031, F3_W, 32'h33333333, 32'h0, 1'b1);
        do_store("SW 032 mis", 9'h032, F3_W, 32'h44444444, 1'b1);
        do_load("LW 030 kept", 9'h030, F3_W, 32'h22222222, 1'b0);

        // idle cycle: no pulse, rd_data holds
        @(posedge clk);
        #1;
        check("idle valid", 32'(rd_valid), 32'd0);
        check("idle hold", rd_data, 32'h22222222);

        // asynchronous reset clears pending pulses
        do_load("LW 031 pre-rst", 9'h031, F3_W, 32'h0, 1'b1);
        reset = 1'b1;
        #1;
        check("async rst valid", 32'(rd_valid), 32'd0);
        check("async rst mis", 32'(misaligned), 32'd0);
        @(negedge clk);
        reset = 1'b0;
`ifdef DMEM_CLEAR_EN
        wait_ready(cyc);
        check("clear cycles final", 32'(cyc), 32'd128);
        do_load("LW 030 post-rst", 9'h030, F3_W, 32'h0, 1'b0);
`else
        do_load("LW 030 post-rst", 9'h030, F3_W, 32'h22222222, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
